level_to_pulse_array: RTL and testbench

LEVEL_TO_PULSE_ARRAY -- requirements
Module: level_to_pulse_array

---
 rtl/ltp_pkg.sv | 59 +++++
 rtl/ltp_channel.sv | 204 ++++++++++++++++++++
 rtl/level_to_pulse_array.sv | 37 +++
 tb/tb_level_to_pulse_array.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ltp_pkg.sv
// ltp_pkg: shared definitions for the level_to_pulse_array block.
// Holds the Mode encodings, the per-channel FSM state encoding, the
// released-level constant and small decode helpers for the pulse mode.
package ltp_pkg;

  // Pulse mode encodings (shared by all channels); 2'b11 behaves as press
  localparam logic [1:0] LTP_MODE_PRESS   = 2'b00;
  localparam logic [1:0] LTP_MODE_RELEASE = 2'b01;
  localparam logic [1:0] LTP_MODE_BOTH    = 2'b10;

  // Raw button lines are active-low, so an idle button reads as 1
  localparam logic LTP_LEVEL_RELEASED = 1'b1;

  // Per-channel debounce FSM
  typedef enum logic [1:0] {
    LTP_RELEASED     = 2'b00,
    LTP_PRESS_WAIT   = 2'b01,
    LTP_PRESSED      = 2'b10,
    LTP_RELEASE_WAIT = 2'b11
  } ltp_state_e;

  // True when an accepted press (or an auto-repeat) should raise Pulse
  function automatic logic ltp_press_enabled(input logic [1:0] mode);
    logic en;
    case (mode)
      LTP_MODE_PRESS:   en = 1'b1;
      LTP_MODE_RELEASE: en = 1'b0;
      LTP_MODE_BOTH:    en = 1'b1;
      default:          en = 1'b1;
    endcase
    return en;
  endfunction

  // True when an accepted release should raise Pulse
  function automatic logic ltp_release_enabled(input logic [1:0] mode);
    logic en;
    case (mode)
      LTP_MODE_PRESS:   en = 1'b0;
      LTP_MODE_RELEASE: en = 1'b1;
      LTP_MODE_BOTH:    en = 1'b1;
      default:          en = 1'b0;
    endcase
    return en;
  endfunction

  // Debounced "held" view of a state: pressed until the release is accepted
  function automatic logic ltp_is_held(input ltp_state_e st);
    logic held;
    case (st)
      LTP_PRESSED:      held = 1'b1;
      LTP_RELEASE_WAIT: held = 1'b1;
      LTP_RELEASED:     held = 1'b0;
      LTP_PRESS_WAIT:   held = 1'b0;
      default:          held = 1'b0;
    endcase
    return held;
  endfunction

endpackage

// File: rtl/ltp_channel.sv
// ltp_channel: one button channel of level_to_pulse_array.
// 2-flop synchronizer -> 4-state debounce FSM with a saturating counter ->
// registered Pulse/Held. Optional auto-repeat is built only when the
// macro LTP_AUTOREPEAT_EN is defined.
module ltp_channel
  import ltp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 250
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Level,
  input  logic [1:0] Mode,
  output logic       Pulse,
  output logic       Held
);

  // Debounce counter sizing; DEBOUNCE_CYCLES >= 2 keeps CW >= 2
  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  // The edge that would bring the count to DEBOUNCE_CYCLES accepts the change
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_r;
  logic          sample_pressed_s;
  ltp_state_e    state_r;
  ltp_state_e    state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic          pulse_r;
  logic          pulse_s;
  logic          held_r;
  logic          held_s;
  logic          rpt_fire_s;

  // Saturating increment so the debounce counter can never wrap
  function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  // Two-flop synchronizer; cleared to the idle (released) line level
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_r <= {2{LTP_LEVEL_RELEASED}};
    end else begin
      sync_r <= {sync_r[0], Level};
    end
  end

  assign sample_pressed_s = (sync_r[1] != LTP_LEVEL_RELEASED);

  // FSM state, debounce counter and registered outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= LTP_RELEASED;
      cnt_r   <= CNT_ZERO;
      pulse_r <= 1'b0;
      held_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      pulse_r <= pulse_s;
      held_r  <= held_s;
    end
  end

  // Next-state and counter: a change is accepted after DEBOUNCE_CYCLES
  // consecutive samples of the new level; any bounce returns to the old state
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      LTP_RELEASED: begin
        if (sample_pressed_s) begin
          state_s = LTP_PRESS_WAIT;
          cnt_s   = CNT_ONE;
        end else begin
          state_s = LTP_RELEASED;
          cnt_s   = CNT_ZERO;
        end
      end
      LTP_PRESS_WAIT: begin
        if (!sample_pressed_s) begin
          state_s = LTP_RELEASED;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r >= DB_LAST) begin
          state_s = LTP_PRESSED;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = LTP_PRESS_WAIT;
          cnt_s   = cnt_inc(cnt_r);
        end
      end
      LTP_PRESSED: begin
        if (!sample_pressed_s) begin
          state_s = LTP_RELEASE_WAIT;
          cnt_s   = CNT_ONE;
        end else begin
          state_s = LTP_PRESSED;
          cnt_s   = CNT_ZERO;
        end
      end
      LTP_RELEASE_WAIT: begin
        if (sample_pressed_s) begin
          state_s = LTP_PRESSED;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r >= DB_LAST) begin
          state_s = LTP_RELEASED;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = LTP_RELEASE_WAIT;
          cnt_s   = cnt_inc(cnt_r);
        end
      end
      default: begin
        state_s = LTP_RELEASED;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Output decode: Mode only matters on the accepting edge (or a repeat edge)
  always_comb begin
    pulse_s = 1'b0;
    held_s  = ltp_is_held(state_s);
    if ((state_r == LTP_PRESS_WAIT) && (state_s == LTP_PRESSED)) begin
      pulse_s = ltp_press_enabled(Mode);
    end else if ((state_r == LTP_RELEASE_WAIT) && (state_s == LTP_RELEASED)) begin
      pulse_s = ltp_release_enabled(Mode);
    end else if (rpt_fire_s) begin
      pulse_s = ltp_press_enabled(Mode);
    end else begin
      pulse_s = 1'b0;
    end
  end

`ifdef LTP_AUTOREPEAT_EN
  // Repeat counter sized for the longer of the two intervals
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX + 1);
  localparam logic [RW-1:0] RPT_ZERO         = RW'(1'b0);
  localparam logic [RW-1:0] RPT_ONE          = RW'(1'b1);
  localparam logic [RW-1:0] RPT_MAXV         = {RW{1'b1}};
  localparam logic [RW-1:0] RPT_DELAY_LAST   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_PERIOD_LAST  = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rpt_cnt_r;
  logic [RW-1:0] rpt_cnt_s;
  logic          rpt_first_r;
  logic          rpt_first_s;
  logic [RW-1:0] rpt_target_s;

  // Repeat counter register; restarts from the delay phase on reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rpt_cnt_r   <= RPT_ZERO;
      rpt_first_r <= 1'b1;
    end else begin
      rpt_cnt_r   <= rpt_cnt_s;
      rpt_first_r <= rpt_first_s;
    end
  end

  // Repeat timing: counts edges spent in PRESSED; first interval is
  // REPEAT_DELAY, later ones REPEAT_PERIOD. Runs independently of Mode.
  always_comb begin
    rpt_fire_s   = 1'b0;
    rpt_cnt_s    = rpt_cnt_r;
    rpt_first_s  = rpt_first_r;
    rpt_target_s = rpt_first_r ? RPT_DELAY_LAST : RPT_PERIOD_LAST;
    if ((state_r != LTP_PRESSED) || (state_s != LTP_PRESSED)) begin
      rpt_cnt_s   = RPT_ZERO;
      rpt_first_s = 1'b1;
    end else if (rpt_cnt_r >= rpt_target_s) begin
      rpt_fire_s  = 1'b1;
      rpt_cnt_s   = RPT_ZERO;
      rpt_first_s = 1'b0;
    end else if (rpt_cnt_r == RPT_MAXV) begin
      rpt_cnt_s   = rpt_cnt_r;
    end else begin
      rpt_cnt_s   = rpt_cnt_r + RPT_ONE;
    end
  end
`else
  // No repeat hardware: a held button yields a single press pulse
  logic unused_rpt_cfg_s;
  assign unused_rpt_cfg_s = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign rpt_fire_s       = 1'b0;
`endif

  assign Pulse = pulse_r;
  assign Held  = held_r;

endmodule

// File: rtl/level_to_pulse_array.sv
// level_to_pulse_array: CHANNELS independent debounced button channels
// turning active-low raw levels into one-cycle event pulses plus a
// debounced held state. Optional auto-repeat: define LTP_AUTOREPEAT_EN.
module level_to_pulse_array
  import ltp_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 250
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [CHANNELS-1:0] Level,
  input  logic [1:0]          Mode,
  output logic [CHANNELS-1:0] Pulse,
  output logic [CHANNELS-1:0] Held
);

  // One fully independent channel per button; each drives its own
  // registered Pulse/Held bit so simultaneous events line up naturally
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    ltp_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .Clock (Clock),
      .Reset (Reset),
      .Level (Level[i]),
      .Mode  (Mode),
      .Pulse (Pulse[i]),
      .Held  (Held[i])
    );
  end

endmodule

// File: tb/tb_level_to_pulse_array.sv
// Scoreboard bench for level_to_pulse_array (CHANNELS=4, DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=5). Expected pulses are queued by the
// stimulus with the edge number they must appear on; a monitor pops them.
module tb_level_to_pulse_array;

  logic       Clock;
  logic       Reset;
  logic [3:0] Level;
  logic [1:0] Mode;
  logic [3:0] Pulse;
  logic [3:0] Held;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  level_to_pulse_array #(
    .CHANNELS        (4),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (5)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Level (Level),
    .Mode  (Mode),
    .Pulse (Pulse),
    .Held  (Held)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Edge counter: after rising edge N (and until the next one) cyc == N
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic push(input int c, input logic [3:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    exp_q.push_back(e);
  endtask

  // Monitor: any nonzero Pulse must match the oldest queued expectation
  always @(negedge Clock) begin
    exp_t e;
    if (Pulse !== 4'h0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(Pulse), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_edge", 32'(cyc), 32'(e.cyc));
        check("pulse_value", 32'(Pulse), 32'(e.val));
      end
    end
  end

  initial begin
    int e0;
    int e1;
    logic glitch [8];
    glitch = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    Reset = 1'b1;
    Level = 4'hF;
    Mode  = 2'b00;

    // Reset state and idle with all buttons released
    tick(3);
    check("reset_pulse", 32'(Pulse), 32'h0);
    check("reset_held", 32'(Held), 32'h0);
    Reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      check("idle_held", 32'(Held), 32'h0);
      check("idle_pulse", 32'(Pulse), 32'h0);
    end

    // Mode 00: single press pulse on ch0, silent release
    Mode = 2'b00;
    e0 = cyc;
    Level = 4'b1110;
    push(e0 + 6, 4'b0001);
`ifdef LTP_AUTOREPEAT_EN
    push(e0 + 16, 4'b0001);
    push(e0 + 21, 4'b0001);
    push(e0 + 26, 4'b0001);
    push(e0 + 31, 4'b0001);
`endif
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      if (k == 5) check("press_held_before", 32'(Held), 32'h0);
      if (k == 6) check("press_held_after", 32'(Held), 32'h1);
    end
    e1 = cyc;
    Level = 4'hF;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k == 5) check("release_held_before", 32'(Held), 32'h1);
      if (k == 6) check("release_held_after", 32'(Held), 32'h0);
    end

    // Glitch on ch2 (3 low, 2 high, 3 low) never reaches the debounce limit
    for (int k = 0; k < 8; k++) begin
      Level = {1'b1, ~glitch[k], 2'b11};
      tick(1);
      check("glitch_held", 32'(Held), 32'h0);
    end
    Level = 4'hF;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      check("glitch_settle_held", 32'(Held), 32'h0);
    end

    // Mode 10: ch1 and ch3 together, pulse on press and on release
    Mode = 2'b10;
    e0 = cyc;
    Level = 4'b0101;
    push(e0 + 6, 4'b1010);
`ifdef LTP_AUTOREPEAT_EN
    push(e0 + 16, 4'b1010);
    push(e0 + 21, 4'b1010);
`endif
    push(e0 + 26, 4'b1010);
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (k == 6) check("both_held_press", 32'(Held), 32'hA);
    end
    Level = 4'hF;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k == 6) check("both_held_release", 32'(Held), 32'h0);
    end

    // Reset at edge 3 of a ch0 debounce discards it; held button re-accepted
    Mode = 2'b00;
    e0 = cyc;
    Level = 4'b1110;
    tick(2);
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    check("midreset_pulse", 32'(Pulse), 32'h0);
    check("midreset_held", 32'(Held), 32'h0);
    push(e0 + 9, 4'b0001);
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k == 5) check("postreset_held_before", 32'(Held), 32'h0);
      if (k == 6) check("postreset_held_after", 32'(Held), 32'h1);
    end
    Level = 4'hF;
    tick(12);
    check("postreset_release_held", 32'(Held), 32'h0);

    // Long hold on ch0: repeats only when the auto-repeat build is selected
    e0 = cyc;
    Level = 4'b1110;
    push(e0 + 6, 4'b0001);
`ifdef LTP_AUTOREPEAT_EN
    for (int r = 16; r <= 41; r += 5) push(e0 + r, 4'b0001);
`endif
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (k == 40) check("long_hold_held", 32'(Held), 32'h1);
    end
    Level = 4'hF;
    tick(12);
    check("long_release_held", 32'(Held), 32'h0);

    // Every queued pulse must have been seen
    tick(10);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_pulse: got none expected %h at edge %0d", e.val, e.cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
